// File: rtl/pixel_writeback_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pixel_writeback_if : pixel stream in, user-buffer master write bus out
// Rev 1.0  initial release
// ----------------------------------------------------------------------------
interface pixel_writeback_if;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        user_buffer_full;
  logic        idle_out;
  logic        user_write_buffer;
  logic [7:0]  data_out;
  logic        rdwr_cntl;
  logic        n_action;
  logic [31:0] address;
  logic [15:0] write_length;

  modport master (
    input  pix_valid, pix_data, user_buffer_full, idle_out,
    output pix_ready, user_write_buffer, data_out, rdwr_cntl, n_action,
           address, write_length
  );

  modport slave (
    output pix_valid, pix_data, user_buffer_full, idle_out,
    input  pix_ready, user_write_buffer, data_out, rdwr_cntl, n_action,
           address, write_length
  );
endinterface
`default_nettype wire

// File: rtl/pixel_writeback.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pixel_writeback : buffers pixel bytes and writes them out burst by burst
// Rev 1.0  initial release
// ----------------------------------------------------------------------------
module pixel_writeback #(
  parameter int FIFO_DEPTH = 8,
  parameter int BURST_LEN  = 16
) (
  input  wire logic        clk,
  input  wire logic        n_rst,
  input  wire logic        i_go,
  input  wire logic [31:0] i_base_addr,
  input  wire logic [31:0] i_pixel_count,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow_err,
  pixel_writeback_if.master bus
);

  localparam int             PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT0  = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [7:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  logic         w_last;
  logic [7:0]   w_head;

  logic [31:0]  r_cur_addr;
  logic [31:0]  r_remaining;
  logic [15:0]  r_burst;
  logic [15:0]  r_sent;
  logic [31:0]  r_address;
  logic [15:0]  r_write_length;
  logic         r_overflow;
  logic [31:0]  w_rem_next;

  function automatic logic [15:0] f_burst(input logic [31:0] rem);
    if (rem < 32'(BURST_LEN)) return rem[15:0];
    else                      return 16'(BURST_LEN);
  endfunction

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_push  = bus.pix_valid && !w_full;
  assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_last  = ((r_sent + 16'd1) == r_burst);
  assign w_rem_next = r_remaining - {16'h0000, r_burst};

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_go) w_state_nxt = (i_pixel_count == 32'd0) ? S_DONE : S_FILL;
      end
      S_FILL: begin
        if (!w_empty && !bus.user_buffer_full) begin
          w_pop = 1'b1;
          if (w_last) w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: w_state_nxt = S_WAIT0;
      S_WAIT0:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.idle_out) w_state_nxt = (w_rem_next == 32'd0) ? S_DONE : S_FILL;
      end
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= bus.pix_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_cur_addr     <= '0;
      r_remaining    <= '0;
      r_burst        <= '0;
      r_sent         <= '0;
      r_address      <= '0;
      r_write_length <= '0;
      r_overflow     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;

      // A drop in the same cycle as an accepted go still leaves the flag set.
      if (r_state == S_IDLE && i_go) r_overflow <= 1'b0;
      if (bus.pix_valid && w_full)   r_overflow <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_go) begin
            r_cur_addr  <= i_base_addr;
            r_remaining <= i_pixel_count;
            r_burst     <= f_burst(i_pixel_count);
            r_sent      <= '0;
          end
        end
        S_FILL: begin
          if (w_pop) begin
            r_sent <= r_sent + 16'd1;
            if (w_last) begin
              r_address      <= r_cur_addr;
              r_write_length <= r_burst;
            end
          end
        end
        S_WAIT: begin
          if (bus.idle_out) begin
            r_cur_addr  <= r_cur_addr + {16'h0000, r_burst};
            r_remaining <= w_rem_next;
            r_burst     <= f_burst(w_rem_next);
            r_sent      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pix_ready         = !w_full;
  assign bus.user_write_buffer = w_pop;
  assign bus.data_out          = w_pop ? w_head : 8'h00;
  assign bus.rdwr_cntl         = !(r_state == S_LAUNCH || r_state == S_WAIT0 ||
                                   r_state == S_WAIT);
  assign bus.n_action          = (r_state != S_LAUNCH);
  assign bus.address           = r_address;
  assign bus.write_length      = r_write_length;

  assign o_busy         = (r_state == S_FILL) || (r_state == S_LAUNCH) ||
                          (r_state == S_WAIT0) || (r_state == S_WAIT);
  assign o_done         = (r_state == S_DONE);
  assign o_overflow_err = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pixel_writeback.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pixel_writeback : directed self-checking bench for pixel_writeback
// Rev 1.0  initial release
// ----------------------------------------------------------------------------
module tb_pixel_writeback;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        i_go = 1'b0;
  logic [31:0] i_base_addr = '0;
  logic [31:0] i_pixel_count = '0;
  logic        o_busy;
  logic        o_done;
  logic        o_overflow_err;

  pixel_writeback_if bus ();

  pixel_writeback #(.FIFO_DEPTH(8), .BURST_LEN(16)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_go           (i_go),
    .i_base_addr    (i_base_addr),
    .i_pixel_count  (i_pixel_count),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_overflow_err (o_overflow_err),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int rise_cyc = 0;
  logic [7:0]  wr_q[$];
  logic [31:0] act_addr_q[$];
  logic [15:0] act_len_q[$];
  logic        act_rw_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus observer: strobes, launches and done pulses, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.user_write_buffer === 1'b1) wr_q.push_back(bus.data_out);
      if (bus.n_action === 1'b0) begin
        act_addr_q.push_back(bus.address);
        act_len_q.push_back(bus.write_length);
        act_rw_q.push_back(bus.rdwr_cntl);
      end
      if (o_done === 1'b1) begin
        if (done_cnt == 0) done_cyc = cyc;
        done_cnt++;
      end
    end
  end

  // Master model: drops idle after a launch, raises it again 3 cycles later.
  initial begin
    bus.idle_out = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.n_action === 1'b0) begin
        bus.idle_out = 1'b0;
        repeat (3) @(negedge clk);
        bus.idle_out = 1'b1;
        rise_cyc = cyc;
      end
    end
  end

  task automatic clear_obs();
    wr_q.delete();
    act_addr_q.delete();
    act_len_q.delete();
    act_rw_q.delete();
    done_cnt = 0;
  endtask

  task automatic offer(input int n, input logic [7:0] b);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.pix_valid = 1'b1;
      bus.pix_data  = b + 8'(i);
    end
    @(negedge clk);
    bus.pix_valid = 1'b0;
  endtask

  task automatic feed(input int n, input logic [7:0] b);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 5000) begin
      @(negedge clk);
      bus.pix_valid = 1'b1;
      bus.pix_data  = b + 8'(i);
      if (bus.pix_ready === 1'b1) i++;
      guard++;
    end
    @(negedge clk);
    bus.pix_valid = 1'b0;
    check("feed_complete", 32'(i), 32'(n));
  endtask

  task automatic pulse_go(input logic [31:0] base, input logic [31:0] count);
    @(negedge clk);
    i_go          = 1'b1;
    i_base_addr   = base;
    i_pixel_count = count;
    @(negedge clk);
    i_go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && done_cnt == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_after"}, 32'(o_busy), 32'd0);
  endtask

  task automatic chk_bytes(input string tag, input int n, input logic [7:0] b);
    check({tag, "_nbytes"}, 32'(wr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_q.size(); i++)
      check({tag, "_byte"}, 32'(wr_q[i]), 32'(b + 8'(i)));
  endtask

  task automatic chk_act(input string tag, input int idx, input logic [31:0] a, input logic [15:0] l);
    if (idx < act_addr_q.size()) begin
      check({tag, "_addr"}, act_addr_q[idx], a);
      check({tag, "_len"}, 32'(act_len_q[idx]), 32'(l));
      check({tag, "_rw"}, 32'(act_rw_q[idx]), 32'd0);
    end else begin
      check({tag, "_present"}, 32'(act_addr_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_wr"},     32'(bus.user_write_buffer), 32'd0);
    check({tag, "_dout"},   32'(bus.data_out), 32'd0);
    check({tag, "_rw"},     32'(bus.rdwr_cntl), 32'd1);
    check({tag, "_nact"},   32'(bus.n_action), 32'd1);
    check({tag, "_addr"},   bus.address, 32'd0);
    check({tag, "_len"},    32'(bus.write_length), 32'd0);
    check({tag, "_busy"},   32'(o_busy), 32'd0);
    check({tag, "_done"},   32'(o_done), 32'd0);
    check({tag, "_ovf"},    32'(o_overflow_err), 32'd0);
    check({tag, "_ready"},  32'(bus.pix_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data = 8'h00;
    bus.user_buffer_full = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset("rst_init");
    n_rst = 1'b1;

    // 1: prefilled single burst
    offer(8, 8'h10);
    check("t1_full_ready", 32'(bus.pix_ready), 32'd0);
    clear_obs();
    pulse_go(32'h1000, 32'd8);
    wait_done("t1", 200);
    chk_bytes("t1", 8, 8'h10);
    check("t1_nacts", 32'(act_addr_q.size()), 32'd1);
    chk_act("t1_act", 0, 32'h1000, 16'd8);
    check("t1_done_lat", 32'(done_cyc - rise_cyc), 32'd1);
    check("t1_addr_hold", bus.address, 32'h1000);

    // 2: 40 bytes -> bursts 16,16,8
    clear_obs();
    fork
      feed(40, 8'h40);
      begin
        pulse_go(32'h1000, 32'd40);
        wait_done("t2", 1000);
      end
    join
    chk_bytes("t2", 40, 8'h40);
    check("t2_nacts", 32'(act_addr_q.size()), 32'd3);
    chk_act("t2_act0", 0, 32'h1000, 16'd16);
    chk_act("t2_act1", 1, 32'h1010, 16'd16);
    chk_act("t2_act2", 2, 32'h1020, 16'd8);

    // 3: user_buffer_full stall mid-FILL
    offer(8, 8'h30);
    clear_obs();
    pulse_go(32'h6000, 32'd8);
    for (int g = 0; g < 100 && wr_q.size() < 3; g++) begin
      @(posedge clk); #1;
    end
    bus.user_buffer_full = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t3_stall_bytes", 32'(wr_q.size()), 32'd3);
    bus.user_buffer_full = 1'b0;
    wait_done("t3", 200);
    chk_bytes("t3", 8, 8'h30);
    chk_act("t3_act", 0, 32'h6000, 16'd8);

    // 4: overflow while idle
    offer(10, 8'hA0);
    check("t4_ready", 32'(bus.pix_ready), 32'd0);
    check("t4_ovf_set", 32'(o_overflow_err), 32'd1);
    clear_obs();
    pulse_go(32'h4000, 32'd8);
    check("t4_ovf_clr", 32'(o_overflow_err), 32'd0);
    wait_done("t4", 200);
    chk_bytes("t4", 8, 8'hA0);
    chk_act("t4_act", 0, 32'h4000, 16'd8);
    check("t4_ready_after", 32'(bus.pix_ready), 32'd1);

    // 5a: go while busy is ignored
    offer(4, 8'h50);
    clear_obs();
    pulse_go(32'h2000, 32'd4);
    pulse_go(32'h5000, 32'd2);
    wait_done("t5a", 200);
    chk_bytes("t5a", 4, 8'h50);
    check("t5a_nacts", 32'(act_addr_q.size()), 32'd1);
    chk_act("t5a_act", 0, 32'h2000, 16'd4);

    // 5b: zero-length job
    clear_obs();
    @(negedge clk);
    i_go = 1'b1;
    i_base_addr = 32'h9000;
    i_pixel_count = 32'd0;
    @(negedge clk);
    i_go = 1'b0;
    check("t5b_done", 32'(o_done), 32'd1);
    check("t5b_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    check("t5b_done_once", 32'(o_done), 32'd0);
    repeat (3) @(negedge clk);
    check("t5b_nacts", 32'(act_addr_q.size()), 32'd0);
    check("t5b_nbytes", 32'(wr_q.size()), 32'd0);

    // 6: reset during WAIT, then a fresh job
    offer(8, 8'h60);
    clear_obs();
    pulse_go(32'h7000, 32'd8);
    for (int g = 0; g < 100 && act_addr_q.size() < 1; g++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("t6_in_wait_busy", 32'(o_busy), 32'd1);
    check("t6_in_wait_rw", 32'(bus.rdwr_cntl), 32'd0);
    n_rst = 1'b0;
    #1;
    chk_reset("t6_rst");
    @(negedge clk);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    offer(3, 8'h70);
    clear_obs();
    pulse_go(32'h3000, 32'd3);
    wait_done("t6", 200);
    chk_bytes("t6", 3, 8'h70);
    check("t6_nacts", 32'(act_addr_q.size()), 32'd1);
    chk_act("t6_act", 0, 32'h3000, 16'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
